// File: rtl/read_slave.sv
// -----------------------------------------------------------------------------
// read_slave
// Slave end of an AXI3-style read channel pair (AR in, R out). Read-address
// requests go into a small in-order queue. Each request is then returned as a
// burst of R beats from an internal word-addressed memory, using FIXED, INCR
// or WRAP addressing, with SLVERR on illegal or out-of-range beats. The memory
// is filled through a simple preload write port and is not cleared by reset.
//
// Parameters
//   BusWidth  data/address width in bits (4 byte lanes at 32)
//   tagbits   width of ARID/RID
//   MemDepth  number of BusWidth-bit memory words (power of 2)
//   QDepth    request queue entries (power of 2)
//
// Ports
//   ACLK, ARESETn            clock (rising edge), async active-low reset
//   mem_we/waddr/wdata       preload write port (word index)
//   ARID..ARVALID, ARREADY   read-address channel (ARLOCK/ARCACHE/ARPROT ignored)
//   RID..RVALID, RREADY      read-data channel
//
// Handshake: on both channels a transfer happens at a rising edge where
// VALID and READY are both high. A source that raises VALID keeps the payload
// stable until that edge. ARREADY depends only on the queue count. RVALID and
// the R payload are registers and never depend on RREADY combinationally.
// -----------------------------------------------------------------------------
module read_slave #(
   parameter int BusWidth = 32,
   parameter int tagbits  = 1,
   parameter int MemDepth = 64,
   parameter int QDepth   = 2
) (
   input  logic                        ACLK,
   input  logic                        ARESETn,
   input  logic                        mem_we,
   input  logic [$clog2(MemDepth)-1:0] mem_waddr,
   input  logic [BusWidth-1:0]         mem_wdata,
   input  logic [tagbits-1:0]          ARID,
   input  logic [BusWidth-1:0]         ARADDR,
   input  logic [3:0]                  ARLEN,
   input  logic [1:0]                  ARSIZE,
   input  logic [1:0]                  ARBURST,
   input  logic [1:0]                  ARLOCK,
   input  logic [3:0]                  ARCACHE,
   input  logic [2:0]                  ARPROT,
   input  logic                        ARVALID,
   output logic                        ARREADY,
   output logic [tagbits-1:0]          RID,
   output logic [BusWidth-1:0]         RDATA,
   output logic [1:0]                  RRESP,
   output logic                        RLAST,
   output logic                        RVALID,
   input  logic                        RREADY
);

   localparam int AW  = $clog2(MemDepth);
   localparam int QW  = (QDepth > 1) ? $clog2(QDepth) : 1;
   localparam int QCW = QW + 1;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   // Protection/cache/lock attributes carry no meaning for this memory.
   logic unused_attr;
   assign unused_attr = ^{ARLOCK, ARCACHE, ARPROT};

   // ---------------------------------------------------------------- storage
   logic [BusWidth-1:0] mem [MemDepth];

   logic [tagbits-1:0]  q_id    [QDepth];
   logic [BusWidth-1:0] q_addr  [QDepth];
   logic [3:0]          q_len   [QDepth];
   logic [1:0]          q_size  [QDepth];
   logic [1:0]          q_burst [QDepth];

   logic [QW-1:0]  wr_ptr;
   logic [QW-1:0]  rd_ptr;
   logic [QCW-1:0] q_count;

   // ------------------------------------------------------ burst registers
   logic [0:0]          state;
   logic [BusWidth-1:0] cur_addr;
   logic [3:0]          beats_left;
   logic [BusWidth-1:0] r_step;
   logic [BusWidth-1:0] r_mask;   // wrap container size minus one
   logic [1:0]          r_mode;   // addressing actually used (after error fallback)
   logic                r_err;    // whole-burst error (size/burst/wrap illegal)

   logic push;
   logic pop;

   assign ARREADY = (q_count != QCW'(QDepth));
   assign push    = ARVALID & ARREADY;
   assign pop     = (state == S_IDLE) && (q_count != '0);

   // ------------------------------------------------- queue head decode
   logic [BusWidth-1:0] h_addr;
   logic [3:0]          h_len;
   logic [1:0]          h_size;
   logic [1:0]          h_burst;
   logic [BusWidth-1:0] h_step;
   logic [BusWidth-1:0] h_mask;
   logic                h_len_ok;
   logic                h_aligned;
   logic [1:0]          h_mode;
   logic                h_err;

   always_comb begin
      h_addr    = q_addr[rd_ptr];
      h_len     = q_len[rd_ptr];
      h_size    = q_size[rd_ptr];
      h_burst   = q_burst[rd_ptr];
      h_step    = BusWidth'(1) << h_size;
      h_mask    = ((BusWidth'(h_len) + BusWidth'(1)) << h_size) - BusWidth'(1);
      h_len_ok  = (h_len == 4'd1) || (h_len == 4'd3) || (h_len == 4'd7) || (h_len == 4'd15);
      h_aligned = ((h_addr & (h_step - BusWidth'(1))) == '0);
      h_mode    = h_burst;
      h_err     = (h_size == 2'b11);
      // Illegal requests still get a full-length burst; only the addressing
      // falls back to something well defined.
      if (h_burst == 2'b11) begin
         h_mode = BURST_FIXED;
         h_err  = 1'b1;
      end else if ((h_burst == BURST_WRAP) && (!h_len_ok || !h_aligned)) begin
         h_mode = BURST_INCR;
         h_err  = 1'b1;
      end
   end

   // ------------------------------------------------ next beat address
   logic [BusWidth-1:0] inc_addr;
   logic [BusWidth-1:0] nxt_addr;

   always_comb begin
      inc_addr = cur_addr + r_step;
      case (r_mode)
         BURST_FIXED: nxt_addr = cur_addr;
         // The container is aligned to its own size, so the upper bits of the
         // current address are the wrap base.
         BURST_WRAP:  nxt_addr = (cur_addr & ~r_mask) | (inc_addr & r_mask);
         default:     nxt_addr = inc_addr;
      endcase
   end

   // -------------------------------------------- beat data/response load
   logic [BusWidth-1:0] ld_addr;
   logic                ld_bad;
   logic [BusWidth-1:0] ld_data;
   logic [1:0]          ld_resp;

   always_comb begin
      if (state == S_IDLE) begin
         ld_addr = h_addr;
         ld_bad  = h_err;
      end else begin
         ld_addr = nxt_addr;
         ld_bad  = r_err;
      end
      // Any byte address at or above MemDepth*4 is outside the memory.
      if ((ld_addr >> (AW + 2)) != '0) begin
         ld_bad = 1'b1;
      end
      // The read is combinational from the array, so a preload write in the
      // same cycle lands after the beat has captured the old word.
      ld_data = ld_bad ? '0 : mem[ld_addr[AW+1:2]];
      ld_resp = ld_bad ? RESP_SLVERR : RESP_OKAY;
   end

   // ------------------------------------------------------- storage writes
   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge ACLK) begin
      if (push) begin
         q_id[wr_ptr]    <= ARID;
         q_addr[wr_ptr]  <= ARADDR;
         q_len[wr_ptr]   <= ARLEN;
         q_size[wr_ptr]  <= ARSIZE;
         q_burst[wr_ptr] <= ARBURST;
      end
   end

   // --------------------------------------------------- control and R FSM
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         q_count    <= '0;
         cur_addr   <= '0;
         beats_left <= '0;
         r_step     <= '0;
         r_mask     <= '0;
         r_mode     <= BURST_FIXED;
         r_err      <= 1'b0;
         RID        <= '0;
         RDATA      <= '0;
         RRESP      <= RESP_OKAY;
         RLAST      <= 1'b0;
         RVALID     <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   q_count <= q_count + 1'b1;
            2'b01:   q_count <= q_count - 1'b1;
            default: q_count <= q_count;
         endcase

         case (state)
            S_IDLE: begin
               if (pop) begin
                  cur_addr   <= h_addr;
                  beats_left <= h_len;
                  r_step     <= h_step;
                  r_mask     <= h_mask;
                  r_mode     <= h_mode;
                  r_err      <= h_err;
                  RID        <= q_id[rd_ptr];
                  RDATA      <= ld_data;
                  RRESP      <= ld_resp;
                  RVALID     <= 1'b1;
                  RLAST      <= (h_len == 4'd0);
                  state      <= S_BURST;
               end
            end
            S_BURST: begin
               if (RVALID && RREADY) begin
                  if (!RLAST) begin
                     cur_addr   <= nxt_addr;
                     beats_left <= beats_left - 4'd1;
                     RDATA      <= ld_data;
                     RRESP      <= ld_resp;
                     RLAST      <= (beats_left == 4'd1);
                  end else begin
                     RVALID <= 1'b0;
                     RLAST  <= 1'b0;
                     state  <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_read_slave.sv
// -----------------------------------------------------------------------------
// tb_read_slave
// Directed bench for read_slave. The memory is preloaded with mem[i] = i*0x11.
// A table of single-burst vectors (request plus hand-computed beats) is applied
// in a loop. Hand-written sequences then cover backpressure, a full request
// queue with ordering and inter-burst gaps, a preload/read collision, and
// reset in the middle of a burst.
// -----------------------------------------------------------------------------
module tb_read_slave;

   localparam int BW = 32;
   localparam int TB = 1;
   localparam int MD = 64;
   localparam int QD = 2;
   localparam int AW = 6;

   // ------------------------------------------------------ clock and reset
   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   always #5 ACLK = ~ACLK;

   logic          mem_we = 1'b0;
   logic [AW-1:0] mem_waddr = '0;
   logic [BW-1:0] mem_wdata = '0;
   logic [TB-1:0] ARID = '0;
   logic [BW-1:0] ARADDR = '0;
   logic [3:0]    ARLEN = '0;
   logic [1:0]    ARSIZE = '0;
   logic [1:0]    ARBURST = '0;
   logic [1:0]    ARLOCK = '0;
   logic [3:0]    ARCACHE = '0;
   logic [2:0]    ARPROT = '0;
   logic          ARVALID = 1'b0;
   logic          ARREADY;
   logic [TB-1:0] RID;
   logic [BW-1:0] RDATA;
   logic [1:0]    RRESP;
   logic          RLAST;
   logic          RVALID;
   logic          RREADY = 1'b0;

   read_slave #(.BusWidth(BW), .tagbits(TB), .MemDepth(MD), .QDepth(QD)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
      .RREADY(RREADY)
   );

   // ------------------------------------------------------------ scoreboard
   int checks = 0;
   int errors = 0;
   logic [BW-1:0] exp_q[$];
   logic [1:0]    exp_resp_q[$];
   logic [TB-1:0] exp_id_q[$];

   typedef struct {
      string           name;
      logic [TB-1:0]   id;
      logic [BW-1:0]   addr;
      logic [3:0]      len;
      logic [1:0]      size;
      logic [1:0]      burst;
      logic [3:0][BW-1:0] data;
      logic [3:0][1:0]    resp;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input string n, input logic [TB-1:0] id, input logic [BW-1:0] addr,
                               input logic [3:0] len, input logic [1:0] size, input logic [1:0] burst,
                               input logic [BW-1:0] d0, input logic [BW-1:0] d1,
                               input logic [BW-1:0] d2, input logic [BW-1:0] d3,
                               input logic [1:0] r0, input logic [1:0] r1,
                               input logic [1:0] r2, input logic [1:0] r3);
      vec_t v;
      v.name = n; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
      v.data = {d3, d2, d1, d0};
      v.resp = {r3, r2, r1, r0};
      return v;
   endfunction

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------- driver tasks
   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // Returns 1 time unit after the edge at which the AR handshake happened.
   task automatic issue_ar(input logic [TB-1:0] id, input logic [BW-1:0] addr, input logic [3:0] len,
                           input logic [1:0] size, input logic [1:0] burst);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARVALID = 1'b1;
      for (int i = 0; i < 200 && !ARREADY; i++) step();
      if (!ARREADY) begin
         checks++;
         errors++;
         $display("FAIL ar_timeout: got ARREADY=0 for 200 cycles, expected 1");
      end
      step();
      ARVALID = 1'b0;
   endtask

   task automatic wait_rvalid(input string name);
      for (int i = 0; i < 50 && !RVALID; i++) step();
      if (!RVALID) begin
         checks++;
         errors++;
         $display("FAIL %s_rvalid_timeout: got RVALID=0 for 50 cycles, expected 1", name);
      end
   endtask

   // Expects RREADY=1; checks the presented beat and lets it be accepted.
   task automatic collect_beat(input string name, input logic [TB-1:0] id, input logic [BW-1:0] data,
                               input logic [1:0] resp, input logic last);
      wait_rvalid(name);
      check({name, "_rid"},   BW'(RID),   BW'(id));
      check({name, "_rdata"}, RDATA,      data);
      check({name, "_rresp"}, BW'(RRESP), BW'(resp));
      check({name, "_rlast"}, BW'(RLAST), BW'(last));
      step();
   endtask

   task automatic run_vec(input vec_t v);
      RREADY = 1'b1;
      issue_ar(v.id, v.addr, v.len, v.size, v.burst);
      check({v.name, "_lat_edge1"}, BW'(RVALID), BW'(0));
      step();
      check({v.name, "_lat_edge2"}, BW'(RVALID), BW'(1));
      for (int b = 0; b <= int'(v.len); b++) begin
         collect_beat($sformatf("%s_b%0d", v.name, b), v.id, v.data[b], v.resp[b], b == int'(v.len));
      end
      check({v.name, "_end_rvalid"}, BW'(RVALID), BW'(0));
   endtask

   // -------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------- main test
   initial begin
      bit            pat[4];
      int            accepted;
      logic          stalled;
      logic [BW-1:0] hold_data;
      logic          hold_last;
      logic [TB-1:0] hold_id;

      vecs[0]  = mk("incr",          1'b1, 32'h10,  4'd3, 2'd2, 2'b01, 32'h44,  32'h55,  32'h66, 32'h77, 2'b00, 2'b00, 2'b00, 2'b00);
      vecs[1]  = mk("wrap",          1'b0, 32'h18,  4'd3, 2'd2, 2'b10, 32'h66,  32'h77,  32'h44, 32'h55, 2'b00, 2'b00, 2'b00, 2'b00);
      vecs[2]  = mk("fixed",         1'b1, 32'h08,  4'd2, 2'd2, 2'b00, 32'h22,  32'h22,  32'h22, 32'h0,  2'b00, 2'b00, 2'b00, 2'b00);
      vecs[3]  = mk("oob",           1'b0, 32'h100, 4'd1, 2'd2, 2'b01, 32'h0,   32'h0,   32'h0,  32'h0,  2'b10, 2'b10, 2'b00, 2'b00);
      vecs[4]  = mk("size8",         1'b1, 32'h00,  4'd1, 2'd3, 2'b01, 32'h0,   32'h0,   32'h0,  32'h0,  2'b10, 2'b10, 2'b00, 2'b00);
      vecs[5]  = mk("wrap_len2",     1'b0, 32'h20,  4'd2, 2'd2, 2'b10, 32'h0,   32'h0,   32'h0,  32'h0,  2'b10, 2'b10, 2'b10, 2'b00);
      vecs[6]  = mk("narrow_incr",   1'b1, 32'h21,  4'd3, 2'd0, 2'b01, 32'h88,  32'h88,  32'h88, 32'h99, 2'b00, 2'b00, 2'b00, 2'b00);
      vecs[7]  = mk("narrow_wrap",   1'b0, 32'h3A,  4'd3, 2'd1, 2'b10, 32'hEE,  32'hFF,  32'hFF, 32'hEE, 2'b00, 2'b00, 2'b00, 2'b00);
      vecs[8]  = mk("edge_incr",     1'b1, 32'hF8,  4'd3, 2'd2, 2'b01, 32'h41E, 32'h42F, 32'h0,  32'h0,  2'b00, 2'b00, 2'b10, 2'b10);
      vecs[9]  = mk("rsvd_burst",    1'b0, 32'h0C,  4'd1, 2'd2, 2'b11, 32'h0,   32'h0,   32'h0,  32'h0,  2'b10, 2'b10, 2'b00, 2'b00);
      vecs[10] = mk("wrap_misalign", 1'b1, 32'h12,  4'd1, 2'd2, 2'b10, 32'h0,   32'h0,   32'h0,  32'h0,  2'b10, 2'b10, 2'b00, 2'b00);
      vecs[11] = mk("single",        1'b0, 32'h04,  4'd0, 2'd2, 2'b01, 32'h11,  32'h0,   32'h0,  32'h0,  2'b00, 2'b00, 2'b00, 2'b00);

      // Reset state, held across a couple of edges.
      step();
      step();
      check("rst_rvalid",  BW'(RVALID),  BW'(0));
      check("rst_rlast",   BW'(RLAST),   BW'(0));
      check("rst_rid",     BW'(RID),     BW'(0));
      check("rst_rdata",   RDATA,        BW'(0));
      check("rst_rresp",   BW'(RRESP),   BW'(0));
      check("rst_arready", BW'(ARREADY), BW'(1));
      ARESETn = 1'b1;

      // Preload.
      for (int i = 0; i < MD; i++) begin
         mem_we = 1'b1; mem_waddr = AW'(i); mem_wdata = BW'(i * 32'h11);
         step();
      end
      mem_we = 1'b0;

      // Table-driven bursts.
      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // Backpressure: RREADY pattern 1,0,0,1 on a 4-beat INCR burst.
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      RREADY = 1'b0;
      issue_ar(1'b1, 32'h10, 4'd3, 2'd2, 2'b01);
      accepted = 0;
      stalled = 1'b0;
      hold_data = '0; hold_last = 1'b0; hold_id = '0;
      for (int cyc = 0; cyc < 60 && accepted < 4; cyc++) begin
         RREADY = pat[cyc % 4];
         if (stalled) begin
            check("bp_hold_rvalid", BW'(RVALID), BW'(1));
            check("bp_hold_rdata",  RDATA,       hold_data);
            check("bp_hold_rlast",  BW'(RLAST),  BW'(hold_last));
            check("bp_hold_rid",    BW'(RID),    BW'(hold_id));
         end
         if (RVALID && RREADY) begin
            check($sformatf("bp_b%0d_rdata", accepted), RDATA, BW'(32'h44 + 32'h11 * accepted));
            check($sformatf("bp_b%0d_rlast", accepted), BW'(RLAST), BW'(accepted == 3));
            accepted++;
         end
         stalled = RVALID && !RREADY;
         hold_data = RDATA; hold_last = RLAST; hold_id = RID;
         step();
      end
      check("bp_beats", BW'(accepted), BW'(4));
      RREADY = 1'b1;
      check("bp_no_extra0", BW'(RVALID), BW'(0));
      step();
      check("bp_no_extra1", BW'(RVALID), BW'(0));

      // Queue full and ordering. The first request leaves the queue as soon
      // as it enters the burst registers, so three requests are accepted
      // before the queue is full and the fourth has to wait.
      RREADY = 1'b0;
      exp_q = '{32'h000, 32'h011, 32'h110, 32'h121, 32'h220, 32'h231, 32'h330, 32'h341};
      exp_id_q = '{1'b0, 1'b1, 1'b0, 1'b1};
      issue_ar(1'b0, 32'h00, 4'd1, 2'd2, 2'b01);
      issue_ar(1'b1, 32'h40, 4'd1, 2'd2, 2'b01);
      issue_ar(1'b0, 32'h80, 4'd1, 2'd2, 2'b01);
      check("qfull_arready", BW'(ARREADY), BW'(0));
      fork
         issue_ar(1'b1, 32'hC0, 4'd1, 2'd2, 2'b01);
         begin
            step();
            step();
            check("qfull_arready_held", BW'(ARREADY), BW'(0));
            check("qfull_rvalid_held",  BW'(RVALID),  BW'(1));
            check("qfull_rdata_held",   RDATA,        BW'(32'h000));
            RREADY = 1'b1;
            for (int k = 0; k < 4; k++) begin
               logic [TB-1:0] eid;
               eid = exp_id_q.pop_front();
               for (int b = 0; b < 2; b++) begin
                  collect_beat($sformatf("q%0d_b%0d", k, b), eid, exp_q.pop_front(), 2'b00, b == 1);
               end
               check($sformatf("q%0d_gap_idle", k), BW'(RVALID), BW'(0));
               if (k < 3) begin
                  step();
                  check($sformatf("q%0d_gap_next", k), BW'(RVALID), BW'(1));
               end
            end
         end
      join
      check("q_sb_empty", BW'(exp_q.size()), BW'(0));

      // Preload write to the word being loaded in the same cycle: old data.
      RREADY = 1'b1;
      issue_ar(1'b0, 32'h0C, 4'd0, 2'd2, 2'b01);
      mem_we = 1'b1; mem_waddr = AW'(3); mem_wdata = 32'hDEADBEEF;
      step();
      mem_we = 1'b0;
      collect_beat("collide_old", 1'b0, 32'h33, 2'b00, 1'b1);
      issue_ar(1'b1, 32'h0C, 4'd0, 2'd2, 2'b01);
      step();
      collect_beat("collide_new", 1'b1, 32'hDEADBEEF, 2'b00, 1'b1);
      mem_we = 1'b1; mem_waddr = AW'(3); mem_wdata = 32'h33;
      step();
      mem_we = 1'b0;

      // Reset while beat 2 of 4 is presented.
      RREADY = 1'b1;
      issue_ar(1'b1, 32'h10, 4'd3, 2'd2, 2'b01);
      step();
      check("rst_mid_b0", RDATA, BW'(32'h44));
      step();
      check("rst_mid_b1", RDATA, BW'(32'h55));
      #2;
      ARESETn = 1'b0;
      #1;
      check("rst_mid_rvalid",  BW'(RVALID),  BW'(0));
      check("rst_mid_arready", BW'(ARREADY), BW'(1));
      check("rst_mid_rlast",   BW'(RLAST),   BW'(0));
      check("rst_mid_rdata",   RDATA,        BW'(0));
      step();
      ARESETn = 1'b1;
      step();
      check("rst_after_rvalid", BW'(RVALID), BW'(0));
      step();
      check("rst_after_rvalid2", BW'(RVALID), BW'(0));
      run_vec(mk("post_rst_wrap", 1'b0, 32'h18, 4'd3, 2'd2, 2'b10, 32'h66, 32'h77, 32'h44, 32'h55,
                 2'b00, 2'b00, 2'b00, 2'b00));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
